reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised, scoreboarded successor to the processor's 8×8-bit register file. It adds:
- configurable data width and register count;
- an optional hardwired zero register;
- same-cycle write-to-read bypass;
- a per-register pending (scoreboard) bit that raises a stall when a source register awaits a multi-cycle producer, such as a memory load under BUSYWAIT;
- a multi-cycle CLEAR sweep.

It sits between the instruction decoder, ALU/data-memory writeback and the control unit's stall logic.

## Interface
- DATA_WIDTH, 8, register width in bits
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH registers
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes/reserves
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high; sampled on rising CLK, overrides every other input
- IN  in  DATA_WIDTH  write data
- INADDRESS  in  ADDR_WIDTH  write address
- WRITE  in  1  write enable
- BUSYWAIT  in  1  memory stall; blocks WRITE and RESERVE while high
- RESERVE  in  1  mark RESADDRESS pending
- RESADDRESS  in  ADDR_WIDTH  register to reserve
- CLEAR  in  1  start clear sweep (level sampled at rising edge)
- OUT1ADDRESS, OUT2ADDRESS  in  ADDR_WIDTH  read addresses
- OUT1, OUT2  out  DATA_WIDTH  read data
- STALL  out  1  a source register is pending or a sweep is active
- CLEAR_BUSY  out  1  clear sweep in progress

## Operation
- Storage: DEPTH × DATA_WIDTH data array and DEPTH pending bits.
- Write occurs when WRITE & !BUSYWAIT & !CLEAR_BUSY & !RESET. Effect: reg[INADDRESS] <= IN and pending[INADDRESS] <= 0.
- Reserve occurs when RESERVE & !BUSYWAIT & !CLEAR_BUSY & !RESET. Effect: pending[RESADDRESS] <= 1.
- Write and reserve to the same address in the same cycle: data is written and the pending bit ends at 1 (reserve wins).
- Read ports are combinational: OUTx = reg[OUTxADDRESS].
- Bypass: if the write qualifier is true and INADDRESS == OUTxADDRESS, then OUTx = IN and that port's pending bit is ignored.
- ZERO_REG=1: address 0 always reads 0. Writes, reserves and bypass to address 0 have no effect.
- STALL = (pending[OUT1ADDRESS] & !bypass1) | (pending[OUT2ADDRESS] & !bypass2) | CLEAR_BUSY.
- Sweep FSM has two states, IDLE and SWEEP, with an ADDR_WIDTH-bit counter.
  - IDLE to SWEEP: CLEAR=1 at an edge; counter <= 0.
  - In SWEEP, each edge does reg[cnt] <= 0, pending[cnt] <= 0 and cnt <= cnt + 1.
  - SWEEP to IDLE: on the edge that clears cnt = DEPTH-1.
  - A sweep takes exactly DEPTH cycles.
- During SWEEP:
  - CLEAR is ignored (no restart).
  - BUSYWAIT does not pause the sweep.
  - Reads return current array contents: cleared or not-yet-cleared values.
- RESET at an edge:
  - all registers and pending bits <= 0;
  - FSM <= IDLE, counter <= 0;
  - a sweep in progress is aborted;
  - a simultaneous WRITE/RESERVE/CLEAR is discarded.

## Timing
- Write, reserve, sweep step and reset take effect 1 time unit after rising CLK.
- OUT1/OUT2 settle 2 time units after any change of address, array contents or bypass inputs.
- STALL and CLEAR_BUSY have the same 2-time-unit delay.
- Values after reset: OUT1=OUT2=0, STALL=0, CLEAR_BUSY=0, all pending bits 0.
- Write-to-read latency is 0 cycles via bypass, and 1 cycle from the array.
- Reserve-to-STALL is 1 cycle: STALL is visible after the reserving edge.
- A write clears STALL on the bypass cycle, and the array holds the value from the next cycle on.
- CLEAR_BUSY rises after the accepting edge and falls after the DEPTH-th sweep edge.
- Counter wrap: cnt wraps DEPTH-1 to 0 on exit. No state carries over to the next sweep.

## Test plan
- **Write then read:** reset, write 8'hA5 to r3, read OUT1ADDRESS=3 on the next cycle. Required: OUT1=A5 and STALL=0. Also read OUT2ADDRESS=3 in the write cycle itself. Required: OUT2=A5 via bypass.
- **Scoreboard with BUSYWAIT:**
  - RESERVE r5, then read r5. Required: STALL=1.
  - Assert WRITE r5=8'h3C with BUSYWAIT=1 for 3 cycles. Required: r5 unchanged and STALL stays 1.
  - Drop BUSYWAIT. Required: OUT1=3C in the same cycle, then STALL=0.
- **Same-address write and reserve:** WRITE r2=8'h11 and RESERVE r2 together. Required: next cycle r2 reads 11 with STALL=1.
- **Clear sweep (DEPTH=8):**
  - Fill all registers with 8'hFF, then pulse CLEAR. Required: CLEAR_BUSY=1 for exactly 8 cycles, and r0..r7 reach 0 in ascending order.
  - Assert WRITE r7=8'h55 during the sweep. Required: ignored, r7=0 at the end.
  - Assert CLEAR again mid-sweep. Required: no restart.
- **Reset mid-sweep:** assert RESET at sweep cycle 3. Required: all registers 0, CLEAR_BUSY=0 and STALL=0 on the next cycle. A simultaneous WRITE r1=8'h77 is discarded.
- **Parameters DATA_WIDTH=16, ADDR_WIDTH=4, ZERO_REG=1:**
  - Write 16'hBEEF to r0. Required: OUT1 at r0 = 0, no bypass.
  - Write 16'hBEEF to r15. Required: reads BEEF.
  - Sweep. Required: lasts 16 cycles.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register file with write bypass, per-register scoreboard
// and a multi-cycle clear sweep.
module reg_file_sb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic                  BUSYWAIT,
    input  logic                  RESERVE,
    input  logic [ADDR_WIDTH-1:0] RESADDRESS,
    input  logic                  CLEAR,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic                  STALL,
    output logic                  CLEAR_BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]        pending;

    logic wr_ok;
    logic rs_ok;
    logic bypass1;
    logic bypass2;
    logic zero1;
    logic zero2;

    assign CLEAR_BUSY = (state == SWEEP);

    // Register 0 is simply never written or reserved when hardwired.
    assign wr_ok = WRITE & ~BUSYWAIT & ~CLEAR_BUSY & ~RESET &
                   ~((ZERO_REG != 0) && (INADDRESS == '0));
    assign rs_ok = RESERVE & ~BUSYWAIT & ~CLEAR_BUSY & ~RESET &
                   ~((ZERO_REG != 0) && (RESADDRESS == '0));

    assign bypass1 = wr_ok & (INADDRESS == OUT1ADDRESS);
    assign bypass2 = wr_ok & (INADDRESS == OUT2ADDRESS);
    assign zero1   = (ZERO_REG != 0) && (OUT1ADDRESS == '0);
    assign zero2   = (ZERO_REG != 0) && (OUT2ADDRESS == '0);

    always_comb begin
        OUT1 = regs[OUT1ADDRESS];
        OUT2 = regs[OUT2ADDRESS];
        if (bypass1) OUT1 = IN;
        if (bypass2) OUT2 = IN;
        if (zero1)   OUT1 = '0;
        if (zero2)   OUT2 = '0;
    end

    assign STALL = (pending[OUT1ADDRESS] & ~bypass1) |
                   (pending[OUT2ADDRESS] & ~bypass2) |
                   CLEAR_BUSY;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (CLEAR) state_nxt = SWEEP;
            SWEEP: if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == SWEEP) begin
                regs[cnt]    <= '0;
                pending[cnt] <= 1'b0;
                cnt          <= cnt + 1'b1;
            end else if (CLEAR) begin
                cnt <= '0;
            end
            if (wr_ok) begin
                regs[INADDRESS]    <= IN;
                pending[INADDRESS] <= 1'b0;
            end
            // Reserve after write so a same-address pair leaves it pending.
            if (rs_ok) pending[RESADDRESS] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb, default and
// 16-bit/16-entry/zero-register configurations.
module tb_reg_file_sb;

    logic CLK = 1'b0;
    logic RESET, WRITE, BUSYWAIT, RESERVE, CLEAR;

    logic [7:0]  in8, o18, o28;
    logic [2:0]  ia8, ra8, o1a8, o2a8;
    logic        st8, cb8;

    logic [15:0] in16, o116, o216;
    logic [3:0]  ia16, ra16, o1a16, o2a16;
    logic        st16, cb16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    reg_file_sb u8 (
        .CLK(CLK), .RESET(RESET), .IN(in8), .INADDRESS(ia8),
        .WRITE(WRITE), .BUSYWAIT(BUSYWAIT), .RESERVE(RESERVE),
        .RESADDRESS(ra8), .CLEAR(CLEAR), .OUT1ADDRESS(o1a8),
        .OUT2ADDRESS(o2a8), .OUT1(o18), .OUT2(o28), .STALL(st8),
        .CLEAR_BUSY(cb8)
    );

    reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1)) u16 (
        .CLK(CLK), .RESET(RESET), .IN(in16), .INADDRESS(ia16),
        .WRITE(WRITE), .BUSYWAIT(BUSYWAIT), .RESERVE(RESERVE),
        .RESADDRESS(ra16), .CLEAR(CLEAR), .OUT1ADDRESS(o1a16),
        .OUT2ADDRESS(o2a16), .OUT1(o116), .OUT2(o216), .STALL(st16),
        .CLEAR_BUSY(cb16)
    );

    task step;
        @(posedge CLK);
        #1;
    endtask

    task test_reset;
        RESET = 1'b1; step(); RESET = 1'b0;
        @(negedge CLK);
        n_cmp++; if (o18 !== 8'h00) begin n_bad++;
            $display("FAIL reset_out1 got %h want 00", o18); end
        n_cmp++; if (o28 !== 8'h00) begin n_bad++;
            $display("FAIL reset_out2 got %h want 00", o28); end
        n_cmp++; if (st8 !== 1'b0) begin n_bad++;
            $display("FAIL reset_stall got %b want 0", st8); end
        n_cmp++; if (cb8 !== 1'b0) begin n_bad++;
            $display("FAIL reset_clear_busy got %b want 0", cb8); end
    endtask

    task test_write_read;
        WRITE = 1'b1; ia8 = 3'd3; in8 = 8'hA5; o1a8 = 3'd0; o2a8 = 3'd3;
        @(negedge CLK);
        n_cmp++; if (o28 !== 8'hA5) begin n_bad++;
            $display("FAIL wr_bypass_out2 got %h want a5", o28); end
        step(); WRITE = 1'b0; o1a8 = 3'd3; o2a8 = 3'd0;
        @(negedge CLK);
        n_cmp++; if (o18 !== 8'hA5) begin n_bad++;
            $display("FAIL wr_array_out1 got %h want a5", o18); end
        n_cmp++; if (st8 !== 1'b0) begin n_bad++;
            $display("FAIL wr_stall got %b want 0", st8); end
    endtask

    task test_scoreboard;
        RESERVE = 1'b1; ra8 = 3'd5; step(); RESERVE = 1'b0;
        o1a8 = 3'd5; o2a8 = 3'd0;
        @(negedge CLK);
        n_cmp++; if (st8 !== 1'b1) begin n_bad++;
            $display("FAIL sb_reserve_stall got %b want 1", st8); end
        WRITE = 1'b1; ia8 = 3'd5; in8 = 8'h3C; BUSYWAIT = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_cmp++; if (o18 !== 8'h00) begin n_bad++;
                $display("FAIL sb_busy_out1[%0d] got %h want 00", k, o18); end
            n_cmp++; if (st8 !== 1'b1) begin n_bad++;
                $display("FAIL sb_busy_stall[%0d] got %b want 1", k, st8); end
            step();
        end
        BUSYWAIT = 1'b0;
        @(negedge CLK);
        n_cmp++; if (o18 !== 8'h3C) begin n_bad++;
            $display("FAIL sb_bypass_out1 got %h want 3c", o18); end
        n_cmp++; if (st8 !== 1'b0) begin n_bad++;
            $display("FAIL sb_bypass_stall got %b want 0", st8); end
        step(); WRITE = 1'b0;
        @(negedge CLK);
        n_cmp++; if (o18 !== 8'h3C) begin n_bad++;
            $display("FAIL sb_array_out1 got %h want 3c", o18); end
        n_cmp++; if (st8 !== 1'b0) begin n_bad++;
            $display("FAIL sb_array_stall got %b want 0", st8); end
    endtask

    task test_same_addr;
        WRITE = 1'b1; ia8 = 3'd2; in8 = 8'h11;
        RESERVE = 1'b1; ra8 = 3'd2; o1a8 = 3'd2; o2a8 = 3'd0;
        step(); WRITE = 1'b0; RESERVE = 1'b0;
        @(negedge CLK);
        n_cmp++; if (o18 !== 8'h11) begin n_bad++;
            $display("FAIL same_out1 got %h want 11", o18); end
        n_cmp++; if (st8 !== 1'b1) begin n_bad++;
            $display("FAIL same_stall got %b want 1", st8); end
    endtask

    task test_sweep;
        for (int i = 0; i < 8; i++) begin
            WRITE = 1'b1; ia8 = 3'(i); in8 = 8'hFF; step();
        end
        WRITE = 1'b0; o1a8 = 3'd7; o2a8 = 3'd2; CLEAR = 1'b1;
        @(negedge CLK);
        n_cmp++; if (o18 !== 8'hFF) begin n_bad++;
            $display("FAIL sw_fill got %h want ff", o18); end
        n_cmp++; if (cb8 !== 1'b0) begin n_bad++;
            $display("FAIL sw_busy_pre got %b want 0", cb8); end
        step(); CLEAR = 1'b0;
        for (int k = 0; k < 8; k++) begin
            o1a8 = 3'(k);
            o2a8 = (k > 0) ? 3'(k - 1) : 3'd0;
            WRITE = (k == 2); ia8 = 3'd7; in8 = 8'h55;
            CLEAR = (k == 4);
            @(negedge CLK);
            n_cmp++; if (cb8 !== 1'b1) begin n_bad++;
                $display("FAIL sw_busy[%0d] got %b want 1", k, cb8); end
            n_cmp++; if (st8 !== 1'b1) begin n_bad++;
                $display("FAIL sw_stall[%0d] got %b want 1", k, st8); end
            n_cmp++; if (o18 !== 8'hFF) begin n_bad++;
                $display("FAIL sw_pending[%0d] got %h want ff", k, o18); end
            if (k > 0) begin
                n_cmp++; if (o28 !== 8'h00) begin n_bad++;
                    $display("FAIL sw_cleared[%0d] got %h want 00", k, o28); end
            end
            step();
        end
        WRITE = 1'b0; CLEAR = 1'b0; o1a8 = 3'd7; o2a8 = 3'd0;
        @(negedge CLK);
        n_cmp++; if (cb8 !== 1'b0) begin n_bad++;
            $display("FAIL sw_busy_end got %b want 0", cb8); end
        n_cmp++; if (o18 !== 8'h00) begin n_bad++;
            $display("FAIL sw_r7_end got %h want 00", o18); end
        n_cmp++; if (st8 !== 1'b0) begin n_bad++;
            $display("FAIL sw_stall_end got %b want 0", st8); end
        step();
        @(negedge CLK);
        n_cmp++; if (cb8 !== 1'b0) begin n_bad++;
            $display("FAIL sw_no_restart got %b want 0", cb8); end
    endtask

    task test_reset_sweep;
        WRITE = 1'b1; ia8 = 3'd4; in8 = 8'hBB; step();
        ia8 = 3'd1; in8 = 8'hAA; RESERVE = 1'b1; ra8 = 3'd6; step();
        WRITE = 1'b0; RESERVE = 1'b0; o1a8 = 3'd6; o2a8 = 3'd1;
        @(negedge CLK);
        n_cmp++; if (st8 !== 1'b1) begin n_bad++;
            $display("FAIL rs_pre_stall got %b want 1", st8); end
        CLEAR = 1'b1; step(); CLEAR = 1'b0;
        for (int k = 0; k < 3; k++) step();
        RESET = 1'b1; WRITE = 1'b1; ia8 = 3'd1; in8 = 8'h77;
        step(); RESET = 1'b0; WRITE = 1'b0; o1a8 = 3'd6; o2a8 = 3'd1;
        @(negedge CLK);
        n_cmp++; if (cb8 !== 1'b0) begin n_bad++;
            $display("FAIL rs_busy got %b want 0", cb8); end
        n_cmp++; if (st8 !== 1'b0) begin n_bad++;
            $display("FAIL rs_stall got %b want 0", st8); end
        n_cmp++; if (o28 !== 8'h00) begin n_bad++;
            $display("FAIL rs_r1 got %h want 00", o28); end
        o1a8 = 3'd4;
        @(negedge CLK);
        n_cmp++; if (o18 !== 8'h00) begin n_bad++;
            $display("FAIL rs_r4 got %h want 00", o18); end
        step();
        @(negedge CLK);
        n_cmp++; if (cb8 !== 1'b0) begin n_bad++;
            $display("FAIL rs_no_resume got %b want 0", cb8); end
    endtask

    task test_param16;
        int n;
        RESET = 1'b1; step(); RESET = 1'b0;
        WRITE = 1'b1; ia16 = 4'd0; in16 = 16'hBEEF; o1a16 = 4'd0; o2a16 = 4'd15;
        @(negedge CLK);
        n_cmp++; if (o116 !== 16'h0000) begin n_bad++;
            $display("FAIL p16_r0_bypass got %h want 0000", o116); end
        step(); ia16 = 4'd15;
        @(negedge CLK);
        n_cmp++; if (o116 !== 16'h0000) begin n_bad++;
            $display("FAIL p16_r0_array got %h want 0000", o116); end
        n_cmp++; if (o216 !== 16'hBEEF) begin n_bad++;
            $display("FAIL p16_r15_bypass got %h want beef", o216); end
        step(); WRITE = 1'b0; RESERVE = 1'b1; ra16 = 4'd0; step(); RESERVE = 1'b0;
        @(negedge CLK);
        n_cmp++; if (o216 !== 16'hBEEF) begin n_bad++;
            $display("FAIL p16_r15_array got %h want beef", o216); end
        n_cmp++; if (st16 !== 1'b0) begin n_bad++;
            $display("FAIL p16_r0_reserve got %b want 0", st16); end
        CLEAR = 1'b1; step(); CLEAR = 1'b0;
        n = 0;
        @(negedge CLK);
        while (cb16 === 1'b1 && n < 40) begin
            n++; step(); @(negedge CLK);
        end
        n_cmp++; if (n != 16) begin n_bad++;
            $display("FAIL p16_sweep_len got %0d want 16", n); end
        n_cmp++; if (o216 !== 16'h0000) begin n_bad++;
            $display("FAIL p16_r15_swept got %h want 0000", o216); end
    endtask

    initial begin
        RESET = 1'b0; WRITE = 1'b0; BUSYWAIT = 1'b0; RESERVE = 1'b0; CLEAR = 1'b0;
        in8 = '0; ia8 = '0; ra8 = '0; o1a8 = '0; o2a8 = '0;
        in16 = '0; ia16 = '0; ra16 = '0; o1a16 = '0; o2a16 = '0;
        step();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_addr();
        test_sweep();
        test_reset_sweep();
        test_param16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
